// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: opcodes, FSM states, strobe bundle and decode helpers
// shared by the hard-wired CPU control unit and its wait timer.
package cpu_ctrl_pkg;

    localparam int WAIT_W = 4;

    localparam logic [4:0] OP_LD   = 5'd0;
    localparam logic [4:0] OP_LDI  = 5'd1;
    localparam logic [4:0] OP_ST   = 5'd2;
    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
    localparam logic [4:0] OP_SHR  = 5'd7;
    localparam logic [4:0] OP_SHRA = 5'd8;
    localparam logic [4:0] OP_SHL  = 5'd9;
    localparam logic [4:0] OP_ROR  = 5'd10;
    localparam logic [4:0] OP_ROL  = 5'd11;
    localparam logic [4:0] OP_ADDI = 5'd12;
    localparam logic [4:0] OP_ANDI = 5'd13;
    localparam logic [4:0] OP_ORI  = 5'd14;
    localparam logic [4:0] OP_MUL  = 5'd15;
    localparam logic [4:0] OP_DIV  = 5'd16;
    localparam logic [4:0] OP_NEG  = 5'd17;
    localparam logic [4:0] OP_NOT  = 5'd18;
    localparam logic [4:0] OP_BR   = 5'd19;
    localparam logic [4:0] OP_JR   = 5'd20;
    localparam logic [4:0] OP_IN   = 5'd21;
    localparam logic [4:0] OP_OUT  = 5'd22;
    localparam logic [4:0] OP_MFHI = 5'd23;
    localparam logic [4:0] OP_MFLO = 5'd24;
    localparam logic [4:0] OP_NOP  = 5'd25;
    localparam logic [4:0] OP_HALT = 5'd26;

    typedef enum logic [3:0] {
        S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7,
        S_HALT, S_STEP_WAIT
    } state_t;

    typedef enum logic [3:0] {
        C_LD, C_LDI, C_ST, C_ALU, C_ALUI, C_MULDIV, C_UNARY,
        C_BR, C_JR, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT
    } op_class_t;

    typedef struct packed {
        logic pci;
        logic pc_sel;
        logic pco;
        logic iri;
        logic iro;
        logic mari;
        logic maro;
        logic mdri;
        logic mdro;
        logic opi;
        logic ipi;
        logic ipo;
        logic hii;
        logic hio;
        logic loi;
        logic loo;
        logic ryi;
        logic ryo;
        logic rzi;
        logic rzo;
        logic rzhio;
        logic csigno;
        logic gra;
        logic grb;
        logic grc;
        logic rin;
        logic rout;
        logic baout;
        logic mem_read;
        logic mem_write;
    } ctrl_t;

    // Group opcodes that share an execute sequence; gaps run as NOP.
    function automatic op_class_t op_class(input logic [4:0] op);
        case (op)
            OP_LD:   return C_LD;
            OP_LDI:  return C_LDI;
            OP_ST:   return C_ST;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
            OP_SHRA, OP_SHL, OP_ROR, OP_ROL:
                     return C_ALU;
            OP_ADDI, OP_ANDI, OP_ORI:
                     return C_ALUI;
            OP_MUL, OP_DIV:
                     return C_MULDIV;
            OP_NEG, OP_NOT:
                     return C_UNARY;
            OP_BR:   return C_BR;
            OP_JR:   return C_JR;
            OP_IN:   return C_IN;
            OP_OUT:  return C_OUT;
            OP_MFHI: return C_MFHI;
            OP_MFLO: return C_MFLO;
            OP_HALT: return C_HALT;
            OP_NOP:  return C_NOP;
            default: return C_NOP;
        endcase
    endfunction

    // Final execute step of each class; stop is sampled there.
    function automatic state_t last_state(input op_class_t c);
        case (c)
            C_LD, C_ST:                 return S_T7;
            C_LDI, C_ALU, C_ALUI,
            C_UNARY:                    return S_T5;
            C_MULDIV, C_BR:             return S_T6;
            C_JR, C_IN, C_OUT,
            C_MFHI, C_MFLO:             return S_T3;
            default:                    return S_T2;
        endcase
    endfunction

    // Steps that touch RAM and therefore stretch by the wait count.
    function automatic logic is_mem(input state_t s, input op_class_t c);
        return (s == S_T1)
            || (s == S_T6 && c == C_LD)
            || (s == S_T7 && c == C_ST);
    endfunction

endpackage

// File: rtl/cpu_control_unit_mem_wait_timer.sv
// mem_wait_timer: loadable down-counter that stretches RAM steps;
// done is high while the count sits at zero.
module mem_wait_timer
    import cpu_ctrl_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [WAIT_W-1:0] val_i,
    input  logic              dec_i,
    output logic              done_o
);

    logic [WAIT_W-1:0] cnt_q;

    // Load on entry to a memory step, otherwise count down to zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= val_i;
        end else if (dec_i && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/cpu_control_unit.sv
// cpu_control_unit: hard-wired Moore sequencer for fetch/decode/execute.
// Optional single-step mode under `CTRL_SINGLE_STEP_EN (adds step input).
module cpu_control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 1
) (
    input  logic       clock,
    input  logic       clear,
    input  logic [4:0] ir_op,
    input  logic       con,
    input  logic       stop,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic       step,
`endif
    output logic       pci,
    output logic       pc_sel,
    output logic       pco,
    output logic       iri,
    output logic       iro,
    output logic       mari,
    output logic       maro,
    output logic       mdri,
    output logic       mdro,
    output logic       opi,
    output logic       ipi,
    output logic       ipo,
    output logic       hii,
    output logic       hio,
    output logic       loi,
    output logic       loo,
    output logic       ryi,
    output logic       ryo,
    output logic       rzi,
    output logic       rzo,
    output logic       rzhio,
    output logic       csigno,
    output logic       gra,
    output logic       grb,
    output logic       grc,
    output logic       rin,
    output logic       rout,
    output logic       baout,
    output logic       mem_read,
    output logic       mem_write,
    output logic       run
);

    localparam logic [WAIT_W-1:0] WAIT_V = WAIT_W'(MEM_WAIT);

`ifdef CTRL_SINGLE_STEP_EN
    localparam state_t S_DONE = S_STEP_WAIT;
`else
    localparam state_t S_DONE = S_T0;
`endif

    state_t    state_q, state_d;
    op_class_t cls;
    ctrl_t     str;
    logic      wait_done;
    logic      wait_load;
    logic      mem_step;

    assign cls       = op_class(ir_op);
    assign mem_step  = is_mem(state_q, cls);
    assign wait_load = (state_d != state_q) && is_mem(state_d, cls);

`ifdef CTRL_SINGLE_STEP_EN
    logic step_q;
    logic step_go;

    // Remember last step level so only a rising edge releases STEP_WAIT.
    always_ff @(posedge clock) begin
        if (clear) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step;
        end
    end

    assign step_go = step & ~step_q;
`endif

    mem_wait_timer u_wait (
        .clk_i  (clock),
        .rst_i  (clear),
        .load_i (wait_load),
        .val_i  (WAIT_V),
        .dec_i  (mem_step),
        .done_o (wait_done)
    );

    // Next-state: hold on RAM waits, branch to HALT/idle at instruction end.
    always_comb begin
        state_d = state_q;
        if (state_q == S_HALT) begin
            state_d = S_HALT;
`ifdef CTRL_SINGLE_STEP_EN
        end else if (state_q == S_STEP_WAIT) begin
            state_d = step_go ? S_T0 : S_STEP_WAIT;
`endif
        end else if (mem_step && !wait_done) begin
            state_d = state_q;
        end else if (state_q == S_T2 && cls == C_HALT) begin
            state_d = S_HALT;
        end else if (state_q == last_state(cls)) begin
            state_d = stop ? S_HALT : S_DONE;
        end else begin
            state_d = state_t'(state_q + 4'd1);
        end
    end

    // State register; clear restarts at T0 from any state.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= S_T0;
        end else begin
            state_q <= state_d;
        end
    end

    // Strobe decode from the current state; clear forces all strobes low.
    always_comb begin
        str = '0;
        if (!clear) begin
            unique case (state_q)
                S_T0: begin
                    str.pco  = 1'b1;
                    str.mari = 1'b1;
                    str.pci  = 1'b1;
                end
                S_T1: begin
                    str.mem_read = 1'b1;
                    str.mdri     = 1'b1;
                end
                S_T2: begin
                    str.mdro = 1'b1;
                    str.iri  = 1'b1;
                end
                S_T3: begin
                    case (cls)
                        C_LD, C_LDI, C_ST: begin
                            str.grb   = 1'b1;
                            str.baout = 1'b1;
                            str.ryi   = 1'b1;
                        end
                        C_ALU, C_ALUI, C_UNARY: begin
                            str.grb  = 1'b1;
                            str.rout = 1'b1;
                            str.ryi  = 1'b1;
                        end
                        C_MULDIV: begin
                            str.gra  = 1'b1;
                            str.rout = 1'b1;
                            str.ryi  = 1'b1;
                        end
                        C_BR: begin
                            str.gra  = 1'b1;
                            str.rout = 1'b1;
                        end
                        C_JR: begin
                            str.gra    = 1'b1;
                            str.rout   = 1'b1;
                            str.pci    = 1'b1;
                            str.pc_sel = 1'b1;
                        end
                        C_IN: begin
                            str.ipo = 1'b1;
                            str.gra = 1'b1;
                            str.rin = 1'b1;
                        end
                        C_OUT: begin
                            str.gra  = 1'b1;
                            str.rout = 1'b1;
                            str.opi  = 1'b1;
                        end
                        C_MFHI: begin
                            str.hio = 1'b1;
                            str.gra = 1'b1;
                            str.rin = 1'b1;
                        end
                        C_MFLO: begin
                            str.loo = 1'b1;
                            str.gra = 1'b1;
                            str.rin = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_T4: begin
                    case (cls)
                        C_LD, C_LDI, C_ST, C_ALUI: begin
                            str.csigno = 1'b1;
                            str.rzi    = 1'b1;
                        end
                        C_ALU: begin
                            str.grc  = 1'b1;
                            str.rout = 1'b1;
                            str.rzi  = 1'b1;
                        end
                        C_MULDIV: begin
                            str.grb  = 1'b1;
                            str.rout = 1'b1;
                            str.rzi  = 1'b1;
                        end
                        C_UNARY: str.rzi = 1'b1;
                        C_BR: begin
                            str.pco = 1'b1;
                            str.ryi = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_T5: begin
                    case (cls)
                        C_LD, C_ST: begin
                            str.rzo  = 1'b1;
                            str.mari = 1'b1;
                        end
                        C_LDI, C_ALU, C_ALUI, C_UNARY: begin
                            str.rzo = 1'b1;
                            str.gra = 1'b1;
                            str.rin = 1'b1;
                        end
                        C_MULDIV: begin
                            str.rzo = 1'b1;
                            str.loi = 1'b1;
                        end
                        C_BR: begin
                            str.csigno = 1'b1;
                            str.rzi    = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_T6: begin
                    case (cls)
                        C_LD: begin
                            str.mem_read = 1'b1;
                            str.mdri     = 1'b1;
                        end
                        C_ST: begin
                            str.gra  = 1'b1;
                            str.rout = 1'b1;
                            str.mdri = 1'b1;
                        end
                        C_MULDIV: begin
                            str.rzhio = 1'b1;
                            str.hii   = 1'b1;
                        end
                        C_BR: begin
                            str.rzo    = con;
                            str.pci    = con;
                            str.pc_sel = con;
                        end
                        default: ;
                    endcase
                end
                S_T7: begin
                    case (cls)
                        C_LD: begin
                            str.mdro = 1'b1;
                            str.gra  = 1'b1;
                            str.rin  = 1'b1;
                        end
                        C_ST: str.mem_write = 1'b1;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign run = clear
              || (state_q != S_HALT && state_q != S_STEP_WAIT);

    assign pci       = str.pci;
    assign pc_sel    = str.pc_sel;
    assign pco       = str.pco;
    assign iri       = str.iri;
    assign iro       = str.iro;
    assign mari      = str.mari;
    assign maro      = str.maro;
    assign mdri      = str.mdri;
    assign mdro      = str.mdro;
    assign opi       = str.opi;
    assign ipi       = str.ipi;
    assign ipo       = str.ipo;
    assign hii       = str.hii;
    assign hio       = str.hio;
    assign loi       = str.loi;
    assign loo       = str.loo;
    assign ryi       = str.ryi;
    assign ryo       = str.ryo;
    assign rzi       = str.rzi;
    assign rzo       = str.rzo;
    assign rzhio     = str.rzhio;
    assign csigno    = str.csigno;
    assign gra       = str.gra;
    assign grb       = str.grb;
    assign grc       = str.grc;
    assign rin       = str.rin;
    assign rout      = str.rout;
    assign baout     = str.baout;
    assign mem_read  = str.mem_read;
    assign mem_write = str.mem_write;

endmodule

// File: tb/tb_cpu_control_unit.sv
// tb_cpu_control_unit: random instruction streams on two DUTs
// (MEM_WAIT 1 and 3) checked cycle by cycle against a step-table model.
module tb_cpu_control_unit;

    localparam int PCI = 0,  PC_SEL = 1, PCO = 2,  IRI = 3;
    localparam int IRO = 4,  MARI = 5,   MARO = 6, MDRI = 7;
    localparam int MDRO = 8, OPI = 9,    IPI = 10, IPO = 11;
    localparam int HII = 12, HIO = 13,   LOI = 14, LOO = 15;
    localparam int RYI = 16, RYO = 17,   RZI = 18, RZO = 19;
    localparam int RZHIO = 20, CSIGNO = 21, GRA = 22, GRB = 23;
    localparam int GRC = 24, RIN = 25,   ROUT = 26, BAOUT = 27;
    localparam int MEM_READ = 28, MEM_WRITE = 29;

`ifdef CTRL_SINGLE_STEP_EN
    localparam bit STEP_MODE = 1'b1;
`else
    localparam bit STEP_MODE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       clear_s [2];
    logic       stop_s  [2];
    logic       con_s   [2];
    logic [4:0] op_s    [2];
`ifdef CTRL_SINGLE_STEP_EN
    logic       step_s  [2];
`endif
    wire [29:0] obs     [2];
    wire        run_w   [2];

    int n_chk = 0;
    int n_err = 0;
    logic [29:0] exp_q[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        wire pci, pc_sel, pco, iri, iro, mari, maro, mdri, mdro, opi;
        wire ipi, ipo, hii, hio, loi, loo, ryi, ryo, rzi, rzo;
        wire rzhio, csigno, gra, grb, grc, rin, rout, baout;
        wire mem_read, mem_write, run;

        cpu_control_unit #(.MEM_WAIT(g == 0 ? 1 : 3)) u_dut (
            .clock     (clk),
            .clear     (clear_s[g]),
            .ir_op     (op_s[g]),
            .con       (con_s[g]),
            .stop      (stop_s[g]),
`ifdef CTRL_SINGLE_STEP_EN
            .step      (step_s[g]),
`endif
            .pci       (pci),
            .pc_sel    (pc_sel),
            .pco       (pco),
            .iri       (iri),
            .iro       (iro),
            .mari      (mari),
            .maro      (maro),
            .mdri      (mdri),
            .mdro      (mdro),
            .opi       (opi),
            .ipi       (ipi),
            .ipo       (ipo),
            .hii       (hii),
            .hio       (hio),
            .loi       (loi),
            .loo       (loo),
            .ryi       (ryi),
            .ryo       (ryo),
            .rzi       (rzi),
            .rzo       (rzo),
            .rzhio     (rzhio),
            .csigno    (csigno),
            .gra       (gra),
            .grb       (grb),
            .grc       (grc),
            .rin       (rin),
            .rout      (rout),
            .baout     (baout),
            .mem_read  (mem_read),
            .mem_write (mem_write),
            .run       (run)
        );

        assign obs[g] = {mem_write, mem_read, baout, rout, rin, grc,
                         grb, gra, csigno, rzhio, rzo, rzi, ryo, ryi,
                         loo, loi, hio, hii, ipo, ipi, opi, mdro, mdri,
                         maro, mari, iro, iri, pco, pc_sel, pci};
        assign run_w[g] = run;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, got, want);
        end
    endtask

    function automatic logic [29:0] sb(input int a = -1, input int b = -1,
                                       input int c = -1, input int e = -1);
        logic [29:0] v;
        v = '0;
        if (a >= 0) v[a] = 1'b1;
        if (b >= 0) v[b] = 1'b1;
        if (c >= 0) v[c] = 1'b1;
        if (e >= 0) v[e] = 1'b1;
        return v;
    endfunction

    // Expected strobe set for every cycle of one instruction.
    task automatic build(input int mw, input logic [4:0] op, input logic c);
        int o;
        o = int'(op);
        exp_q.delete();
        exp_q.push_back(sb(PCO, MARI, PCI));
        repeat (mw + 1) exp_q.push_back(sb(MEM_READ, MDRI));
        exp_q.push_back(sb(MDRO, IRI));
        if (o <= 2) begin
            exp_q.push_back(sb(GRB, BAOUT, RYI));
            exp_q.push_back(sb(CSIGNO, RZI));
            if (o == 1) begin
                exp_q.push_back(sb(RZO, GRA, RIN));
            end else begin
                exp_q.push_back(sb(RZO, MARI));
                if (o == 0) begin
                    repeat (mw + 1) exp_q.push_back(sb(MEM_READ, MDRI));
                    exp_q.push_back(sb(MDRO, GRA, RIN));
                end else begin
                    exp_q.push_back(sb(GRA, ROUT, MDRI));
                    repeat (mw + 1) exp_q.push_back(sb(MEM_WRITE));
                end
            end
        end else if (o <= 14) begin
            exp_q.push_back(sb(GRB, ROUT, RYI));
            if (o <= 11) exp_q.push_back(sb(GRC, ROUT, RZI));
            else exp_q.push_back(sb(CSIGNO, RZI));
            exp_q.push_back(sb(RZO, GRA, RIN));
        end else if (o <= 16) begin
            exp_q.push_back(sb(GRA, ROUT, RYI));
            exp_q.push_back(sb(GRB, ROUT, RZI));
            exp_q.push_back(sb(RZO, LOI));
            exp_q.push_back(sb(RZHIO, HII));
        end else if (o <= 18) begin
            exp_q.push_back(sb(GRB, ROUT, RYI));
            exp_q.push_back(sb(RZI));
            exp_q.push_back(sb(RZO, GRA, RIN));
        end else if (o == 19) begin
            exp_q.push_back(sb(GRA, ROUT));
            exp_q.push_back(sb(PCO, RYI));
            exp_q.push_back(sb(CSIGNO, RZI));
            exp_q.push_back(c ? sb(RZO, PCI, PC_SEL) : 30'd0);
        end else if (o == 20) begin
            exp_q.push_back(sb(GRA, ROUT, PCI, PC_SEL));
        end else if (o == 21) begin
            exp_q.push_back(sb(IPO, GRA, RIN));
        end else if (o == 22) begin
            exp_q.push_back(sb(GRA, ROUT, OPI));
        end else if (o == 23) begin
            exp_q.push_back(sb(HIO, GRA, RIN));
        end else if (o == 24) begin
            exp_q.push_back(sb(LOO, GRA, RIN));
        end
    endtask

    task automatic set_step(input int d, input logic v);
`ifdef CTRL_SINGLE_STEP_EN
        step_s[d] = v;
`else
        if (v && d < 0) $display("unused step %0d", d);
`endif
    endtask

    // Cycles with no strobes; called and returns just after a rising edge.
    task automatic idle(input int d, input int n, input logic want_run,
                        input string tag);
        repeat (n) begin
            @(negedge clk);
            chk(tag, 32'(obs[d]), 32'd0);
            chk({tag, "_run"}, 32'(run_w[d]), 32'(want_run));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_clear(input int d, input int n);
        clear_s[d] = 1'b1;
        stop_s[d]  = 1'b0;
        con_s[d]   = 1'b0;
        set_step(d, 1'b0);
        idle(d, n, 1'b1, "clear");
        clear_s[d] = 1'b0;
    endtask

    task automatic run_instr(input int d, input int mw, input logic [4:0] op,
                             input logic c, input logic stp,
                             input int abort_at);
        int last;
        build(mw, op, c);
        last = exp_q.size() - 1;
        op_s[d]   = op;
        con_s[d]  = c;
        stop_s[d] = 1'b0;
        set_step(d, 1'b0);
        for (int i = 0; i <= last; i++) begin
            if (i == abort_at) begin
                do_clear(d, 1);
                return;
            end
            if (i == (last < 4 ? last : 4)) stop_s[d] = stp;
            @(negedge clk);
            chk($sformatf("d%0d op%0d c%0d cyc%0d", d, op, c, i),
                32'(obs[d]), 32'(exp_q[i]));
            chk($sformatf("d%0d op%0d run%0d", d, op, i),
                32'(run_w[d]), 32'd1);
            @(posedge clk);
            #1;
        end
        stop_s[d] = 1'b0;
        if (stp || op == 5'd26) begin
            idle(d, 20, 1'b0, "halt");
            do_clear(d, 2);
        end else if (STEP_MODE) begin
            idle(d, 10, 1'b0, "stepwait");
            set_step(d, 1'b1);
            idle(d, 1, 1'b0, "stepwait");
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            clear_s[d] = 1'b1;
            stop_s[d]  = 1'b0;
            con_s[d]   = 1'b0;
            op_s[d]    = 5'd0;
            set_step(d, 1'b0);
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin : blk
            int mw;
            logic [4:0] op;
            mw = (d == 0) ? 1 : 3;
            do_clear(d, 2);
            run_instr(d, mw, 5'd3, 1'b0, 1'b0, -1);
            run_instr(d, mw, 5'd2, 1'b0, 1'b0, -1);
            run_instr(d, mw, 5'd19, 1'b0, 1'b0, -1);
            run_instr(d, mw, 5'd19, 1'b1, 1'b0, -1);
            run_instr(d, mw, 5'd31, 1'b0, 1'b0, -1);
            run_instr(d, mw, 5'd1, 1'b0, 1'b0, -1);
            run_instr(d, mw, 5'd0, 1'b0, 1'b0, 5);
            run_instr(d, mw, 5'd0, 1'b0, 1'b0, -1);
            repeat (40) begin
                op = 5'($urandom_range(0, 31));
                if (op == 5'd26) op = 5'd25;
                run_instr(d, mw, op, 1'($urandom_range(0, 1)), 1'b0, -1);
            end
            run_instr(d, mw, 5'd15, 1'b0, 1'b1, -1);
            run_instr(d, mw, 5'd26, 1'b0, 1'b0, -1);
            run_instr(d, mw, 5'd25, 1'b0, 1'b1, -1);
            run_instr(d, mw, 5'd20, 1'b0, 1'b0, -1);
            clear_s[d] = 1'b1;
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/cpu_control_unit.md
Name: cpu_control_unit

Overview:
- Hard-wired Moore FSM that sequences the existing datapath: instruction fetch, decode and multi-cycle execute.
- Drives every datapath strobe (register in/out enables, select-encode controls, memory read/write, PC update).
- Decodes opcode ir[31:27]. Branch condition comes from the external CON logic.
- Sits beside the datapath in the CPU top level, sharing its clock and clear.

Parameters:
- MEM_WAIT, 1: extra wait cycles held on every RAM read/write step (0..15).

Ports:
- clock  in  1  system clock
- clear  in  1  synchronous active-high reset
- ir_op  in  5  opcode, ir[31:27]
- con  in  1  branch condition, valid from T4 of BR
- stop  in  1  halt request; sampled at end of each instruction
- pci, pc_sel  out  1 each  PC load; pc_sel 0 = PC+1, 1 = bus
- pco, iri, iro, mari, maro, mdri, mdro  out  1 each  register strobes
- opi, ipi, ipo, hii, hio, loi, loo  out  1 each  port and HI/LO strobes
- ryi, ryo, rzi, rzo, rzhio  out  1 each  ALU register strobes; rzhio drives rz_hi onto bus
- csigno  out  1  sign-extended C onto bus
- gra, grb, grc, rin, rout, baout  out  1 each  select-encode controls
- mem_read, mem_write  out  1 each  RAM strobes
- run  out  1  1 while executing, 0 in HALT

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high. While clear is high at a rising edge: state goes to T0, the wait counter is set to 0, run=1, and all strobes are 0 (outputs are state-decoded).
- Outputs are registered-state Moore decode. Every strobe not listed for a state is 0.
- Fetch:
  - T0: pco, mari, pci (pc_sel=0).
  - T1: mem_read, mdri. Held for MEM_WAIT+1 cycles.
  - T2: mdro, iri.
  - Fetch is 3+MEM_WAIT cycles.
- Opcodes, execute steps from T3:
  - LD 00000: T3 grb baout ryi; T4 csigno rzi; T5 rzo mari; T6 mem_read mdri (+wait); T7 mdro gra rin.
  - LDI 00001: T3 grb baout ryi; T4 csigno rzi; T5 rzo gra rin.
  - ST 00010: T3–T5 as LD; T6 gra rout mdri (mem_read=0); T7 mem_write (+wait).
  - ALU reg 00011–01011: T3 grb rout ryi; T4 grc rout rzi; T5 rzo gra rin.
  - ALU imm 01100–01110: T3 grb rout ryi; T4 csigno rzi; T5 rzo gra rin.
  - MUL 01111, DIV 10000: T3 gra rout ryi; T4 grb rout rzi; T5 rzo loi; T6 rzhio hii.
  - NEG 10001, NOT 10010: T3 grb rout ryi; T4 rzi; T5 rzo gra rin.
  - BR 10011: T3 gra rout; T4 pco ryi; T5 csigno rzi; T6 rzo pci pc_sel=1 only if con=1, else no strobes.
  - JR 10100: T3 gra rout pci pc_sel=1.
  - IN 10101: T3 ipo gra rin.
  - OUT 10110: T3 gra rout opi.
  - MFHI 10111: T3 hio gra rin.
  - MFLO 11000: T3 loo gra rin.
  - NOP 11001: T0 directly after T2.
  - HALT 11010: HALT state.
  - 11011–11111 are undefined and execute as NOP.
- Wait counter: loads MEM_WAIT on entry to any memory step and decrements each cycle. The state advances when the count is 0 (MEM_WAIT=0 means a single cycle). Strobes stay asserted throughout the wait.
- stop: sampled in the last execute state of each instruction. If 1, next state is HALT instead of T0.
- HALT: run=0, all strobes 0. Only clear exits HALT.
- clear mid-instruction aborts it. No partial strobe is issued on the next cycle.

Optional Feature:
- Macro: CTRL_SINGLE_STEP_EN
- With the macro defined:
  - Adds input port step (1 bit) and state STEP_WAIT.
  - After each instruction's last state the FSM enters STEP_WAIT: run=0, all strobes 0.
  - A step high for one or more cycles moves STEP_WAIT to T0 on the next edge. One instruction executes per rising step, edge-detected internally.
  - stop still has priority and goes to HALT.
- Without the macro: no step port and no STEP_WAIT; the FSM proceeds directly to T0.

Decomposition:
- Package cpu_ctrl_pkg holds: opcode localparams (OP_LD..OP_HALT), the state enumeration (S_T0..S_T7, S_HALT, S_STEP_WAIT), and a 4-bit wait-counter width constant.
- One sub-module, mem_wait_timer: loadable down-counter with a done flag, instantiated once.

Test Plan:
- clear high 2 cycles, then ADD 00011 (MEM_WAIT=1) → T0 pco/mari/pci at cycle 1; mem_read for 2 cycles; iri at cycle 4; ryi, rzi, rin on cycles 5, 6, 7; next T0 at cycle 8.
- ST with MEM_WAIT=3 → mem_write held exactly 4 cycles; mem_read stays 0 throughout T6–T7.
- BR with con=0 then con=1 → T6 has no pci on the first; pci=1 with pc_sel=1 for one cycle on the second.
- stop asserted mid-MUL → hii at T6 still issued; then HALT, run=0, no strobes for 20 cycles; clear returns to T0.
- Opcode 11111 → T2 followed directly by T0; zero execute strobes.
- CTRL_SINGLE_STEP_EN: LDI then step pulse after 10 idle cycles → run=0 while idle; next T0 exactly one cycle after step rises.
